// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for hazard_scoreboard_unit: stage register IDs in, stall/flush/forward controls out.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
);
  logic          d_valid, d_uses_rs1, d_uses_rs2, d_memren;
  logic [RW-1:0] d_rs1, d_rs2;
  logic          e_valid, e_memren, e_redirect;
  logic [RW-1:0] e_rs1, e_rs2, e_rd;
  logic [RW-1:0] m_rd, m_rs2;
  logic          m_regwren, m_memren, m_memwren;
  logic [RW-1:0] w_rd;
  logic          w_regwren;
  logic          ld_rsp_valid;
  logic [RW-1:0] ld_rsp_rd;

  logic             stall_if, ifid_wren, ifid_flush, idex_flush;
  logic [1:0]       rs1_sel, rs2_sel;
  logic             wm_fwd_sel;
  logic             sb_busy;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic             watchdog_err;

  modport master (
    output d_valid, d_uses_rs1, d_uses_rs2, d_memren, d_rs1, d_rs2,
           e_valid, e_memren, e_redirect, e_rs1, e_rs2, e_rd,
           m_rd, m_rs2, m_regwren, m_memren, m_memwren,
           w_rd, w_regwren, ld_rsp_valid, ld_rsp_rd,
    input  stall_if, ifid_wren, ifid_flush, idex_flush, rs1_sel, rs2_sel,
           wm_fwd_sel, sb_busy, stall_cycles, flush_events, watchdog_err
  );

  modport slave (
    input  d_valid, d_uses_rs1, d_uses_rs2, d_memren, d_rs1, d_rs2,
           e_valid, e_memren, e_redirect, e_rs1, e_rs2, e_rd,
           m_rd, m_rs2, m_regwren, m_memren, m_memwren,
           w_rd, w_regwren, ld_rsp_valid, ld_rsp_rd,
    output stall_if, ifid_wren, ifid_flush, idex_flush, rs1_sel, rs2_sel,
           wm_fwd_sel, sb_busy, stall_cycles, flush_events, watchdog_err
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller with per-register load scoreboard, outstanding-load limit and stall watchdog.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined; otherwise they read as zero.
module hazard_scoreboard_unit #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned RF_BYPASS  = 0,
  parameter int unsigned WDOG_LIMIT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned OW = 4;
  localparam int unsigned SW = OW + 1;
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;

  logic       e_ld, rsp_take, raw1, raw2, wd1, wd2, full, stall, redir;
  logic       mem_fwd_ok, wb_fwd_ok;
  logic       stall_if_c, ifid_wren_c, ifid_flush_c, idex_flush_c, wm_fwd_c;
  logic [1:0] rs1_sel_c, rs2_sel_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      outst_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Hazard detection and pipeline control; only registered pend bits gate the stall.
  always_comb begin
    e_ld = bus.e_valid & bus.e_memren & (bus.e_rd != RW'(0));
    raw1 = bus.d_uses_rs1 & (bus.d_rs1 != RW'(0)) &
           (pend_q[bus.d_rs1] | (e_ld & (bus.e_rd == bus.d_rs1)));
    raw2 = bus.d_uses_rs2 & (bus.d_rs2 != RW'(0)) &
           (pend_q[bus.d_rs2] | (e_ld & (bus.e_rd == bus.d_rs2)));
    wd1  = (RF_BYPASS == 0) & bus.d_uses_rs1 & bus.w_regwren &
           (bus.w_rd != RW'(0)) & (bus.w_rd == bus.d_rs1);
    wd2  = (RF_BYPASS == 0) & bus.d_uses_rs2 & bus.w_regwren &
           (bus.w_rd != RW'(0)) & (bus.w_rd == bus.d_rs2);
    full = bus.d_memren & (({1'b0, outst_q} + SW'(e_ld)) >= SW'(MAX_OUTST));
    stall = bus.d_valid & (raw1 | raw2 | wd1 | wd2 | full);
    redir = bus.e_valid & bus.e_redirect;

    // A redirect makes the stalled ID instruction wrong-path, so it wins.
    stall_if_c   = stall & ~redir;
    ifid_wren_c  = ~stall | redir;
    ifid_flush_c = redir;
    idex_flush_c = stall | redir;
  end

  // Operand forwarding; a load in MEM has no data yet so it cannot source EX.
  always_comb begin
    mem_fwd_ok = bus.m_regwren & ~bus.m_memren & (bus.m_rd != RW'(0));
    wb_fwd_ok  = bus.w_regwren & (bus.w_rd != RW'(0));
    rs1_sel_c  = 2'b00;
    rs2_sel_c  = 2'b00;
    if (mem_fwd_ok && bus.m_rd == bus.e_rs1)      rs1_sel_c = 2'b01;
    else if (wb_fwd_ok && bus.w_rd == bus.e_rs1)  rs1_sel_c = 2'b10;
    if (mem_fwd_ok && bus.m_rd == bus.e_rs2)      rs2_sel_c = 2'b01;
    else if (wb_fwd_ok && bus.w_rd == bus.e_rs2)  rs2_sel_c = 2'b10;
    wm_fwd_c = bus.m_memwren & wb_fwd_ok & (bus.w_rd == bus.m_rs2);
  end

  // Scoreboard, outstanding-load count and watchdog next state.
  always_comb begin
    pend_d   = pend_q;
    outst_d  = outst_q;
    wdog_d   = '0;
    rsp_take = bus.ld_rsp_valid & (outst_q != OW'(0));

    if (bus.ld_rsp_valid && bus.ld_rsp_rd != RW'(0)) pend_d[bus.ld_rsp_rd] = 1'b0;
    if (e_ld) pend_d[bus.e_rd] = 1'b1;

    if (e_ld && !rsp_take && outst_q != OW'(15)) outst_d = outst_q + OW'(1);
    else if (!e_ld && rsp_take)                  outst_d = outst_q - OW'(1);

    if (stall_if_c) begin
      wdog_d = (wdog_q == WW'(WDOG_LIMIT)) ? wdog_q : wdog_q + WW'(1);
    end
    err_d = err_q | (wdog_d == WW'(WDOG_LIMIT));
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir && flush_cnt_q != '1)      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_events = flush_cnt_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_events = '0;
`endif

  assign bus.stall_if     = stall_if_c;
  assign bus.ifid_wren    = ifid_wren_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_flush   = idex_flush_c;
  assign bus.rs1_sel      = rs1_sel_c;
  assign bus.rs2_sel      = rs2_sel_c;
  assign bus.wm_fwd_sel   = wm_fwd_c;
  assign bus.sb_busy      = |pend_q;
  assign bus.watchdog_err = err_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios plus randomized run against a reference model.
module tb_hazard_scoreboard_unit;
  localparam int NREG = 32;
  localparam int MAXO = 2;
  localparam int WLIM = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_scoreboard_unit_if #(.RW(5), .CNT_W(16)) bus ();

  hazard_scoreboard_unit #(
    .NREG(NREG), .MAX_OUTST(MAXO), .RF_BYPASS(0), .WDOG_LIMIT(WLIM), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.d_valid = 0; bus.d_uses_rs1 = 0; bus.d_uses_rs2 = 0; bus.d_memren = 0;
    bus.d_rs1 = 0; bus.d_rs2 = 0;
    bus.e_valid = 0; bus.e_memren = 0; bus.e_redirect = 0;
    bus.e_rs1 = 0; bus.e_rs2 = 0; bus.e_rd = 0;
    bus.m_rd = 0; bus.m_rs2 = 0; bus.m_regwren = 0; bus.m_memren = 0; bus.m_memwren = 0;
    bus.w_rd = 0; bus.w_regwren = 0; bus.ld_rsp_valid = 0; bus.ld_rsp_rd = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_cmp++; if (bus.stall_if !== 1'b0) begin n_bad++; $display("FAIL reset_stall_if got %b want 0", bus.stall_if); end
    n_cmp++; if (bus.ifid_wren !== 1'b1) begin n_bad++; $display("FAIL reset_ifid_wren got %b want 1", bus.ifid_wren); end
    n_cmp++; if ({bus.ifid_flush, bus.idex_flush} !== 2'b00) begin n_bad++; $display("FAIL reset_flush got %b want 00", {bus.ifid_flush, bus.idex_flush}); end
    n_cmp++; if ({bus.rs1_sel, bus.rs2_sel, bus.wm_fwd_sel} !== 5'b0) begin n_bad++; $display("FAIL reset_sels got %b want 0", {bus.rs1_sel, bus.rs2_sel, bus.wm_fwd_sel}); end
    n_cmp++; if ({bus.sb_busy, bus.watchdog_err} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_err got %b want 00", {bus.sb_busy, bus.watchdog_err}); end
    n_cmp++; if ({bus.stall_cycles, bus.flush_events} !== 32'd0) begin n_bad++; $display("FAIL reset_counters got %h want 0", {bus.stall_cycles, bus.flush_events}); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 5;
    bus.d_valid = 1; bus.d_uses_rs1 = 1; bus.d_rs1 = 5; #1;
    n_cmp++; if ({bus.stall_if, bus.idex_flush, bus.ifid_wren} !== 3'b110) begin n_bad++; $display("FAIL lu_ex_stall got %b want 110", {bus.stall_if, bus.idex_flush, bus.ifid_wren}); end
    step(); bus.e_valid = 0; #1;
    n_cmp++; if ({bus.sb_busy, bus.stall_if} !== 2'b11) begin n_bad++; $display("FAIL lu_pend_stall got %b want 11", {bus.sb_busy, bus.stall_if}); end
    step(); step();
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 5; #1;
    n_cmp++; if (bus.stall_if !== 1'b1) begin n_bad++; $display("FAIL lu_rsp_same_cycle got %b want 1", bus.stall_if); end
    step(); bus.ld_rsp_valid = 0; #1;
    n_cmp++; if ({bus.stall_if, bus.sb_busy, bus.ifid_wren} !== 3'b001) begin n_bad++; $display("FAIL lu_release got %b want 001", {bus.stall_if, bus.sb_busy, bus.ifid_wren}); end
    // WB->ID write-before-read hazard on rs2
    bus.d_uses_rs1 = 0; bus.d_uses_rs2 = 1; bus.d_rs2 = 4; bus.w_regwren = 1; bus.w_rd = 4; #1;
    n_cmp++; if (bus.stall_if !== 1'b1) begin n_bad++; $display("FAIL wb_id_stall got %b want 1", bus.stall_if); end
    bus.w_rd = 0; bus.d_rs2 = 0; #1;
    n_cmp++; if (bus.stall_if !== 1'b0) begin n_bad++; $display("FAIL wb_id_x0 got %b want 0", bus.stall_if); end
  endtask

  task automatic test_outst_limit();
    do_reset();
    bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 1; step();
    bus.e_rd = 2; step();
    bus.e_valid = 0;
    bus.d_valid = 1; bus.d_memren = 1; #1;
    n_cmp++; if (bus.stall_if !== 1'b1) begin n_bad++; $display("FAIL outst_full got %b want 1", bus.stall_if); end
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 1; #1;
    n_cmp++; if (bus.stall_if !== 1'b1) begin n_bad++; $display("FAIL outst_rsp_same got %b want 1", bus.stall_if); end
    step(); bus.ld_rsp_valid = 0; #1;
    n_cmp++; if ({bus.stall_if, bus.sb_busy} !== 2'b01) begin n_bad++; $display("FAIL outst_proceed got %b want 01", {bus.stall_if, bus.sb_busy}); end
    bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 3; #1;
    n_cmp++; if (bus.stall_if !== 1'b1) begin n_bad++; $display("FAIL outst_ex_load got %b want 1", bus.stall_if); end
    // response with nothing outstanding must not underflow the count
    do_reset();
    bus.ld_rsp_valid = 1; step(); bus.ld_rsp_valid = 0;
    bus.d_valid = 1; bus.d_memren = 1; bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 6; #1;
    n_cmp++; if (bus.stall_if !== 1'b0) begin n_bad++; $display("FAIL outst_underflow got %b want 0", bus.stall_if); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 5; bus.e_redirect = 1;
    bus.d_valid = 1; bus.d_uses_rs1 = 1; bus.d_rs1 = 5; #1;
    n_cmp++; if ({bus.stall_if, bus.ifid_wren, bus.ifid_flush, bus.idex_flush} !== 4'b0111) begin n_bad++; $display("FAIL redirect_prio got %b want 0111", {bus.stall_if, bus.ifid_wren, bus.ifid_flush, bus.idex_flush}); end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.m_rd = 3; bus.m_regwren = 1; bus.w_rd = 3; bus.w_regwren = 1; bus.e_rs1 = 3; bus.e_rs2 = 3; #1;
    n_cmp++; if ({bus.rs1_sel, bus.rs2_sel} !== 4'b0101) begin n_bad++; $display("FAIL fwd_mem got %b want 0101", {bus.rs1_sel, bus.rs2_sel}); end
    bus.m_memren = 1; #1;
    n_cmp++; if ({bus.rs1_sel, bus.rs2_sel} !== 4'b1010) begin n_bad++; $display("FAIL fwd_wb_load_in_mem got %b want 1010", {bus.rs1_sel, bus.rs2_sel}); end
    bus.w_regwren = 0; #1;
    n_cmp++; if ({bus.rs1_sel, bus.rs2_sel} !== 4'b0000) begin n_bad++; $display("FAIL fwd_none got %b want 0000", {bus.rs1_sel, bus.rs2_sel}); end
    bus.m_memren = 0; bus.m_rd = 0; bus.w_regwren = 1; bus.w_rd = 0; bus.e_rs1 = 0; bus.e_rs2 = 0; #1;
    n_cmp++; if ({bus.rs1_sel, bus.rs2_sel} !== 4'b0000) begin n_bad++; $display("FAIL fwd_x0 got %b want 0000", {bus.rs1_sel, bus.rs2_sel}); end
  endtask

  task automatic test_store_fwd();
    do_reset();
    bus.m_memwren = 1; bus.m_rs2 = 9; bus.w_rd = 9; bus.w_regwren = 1; #1;
    n_cmp++; if (bus.wm_fwd_sel !== 1'b1) begin n_bad++; $display("FAIL wm_fwd got %b want 1", bus.wm_fwd_sel); end
    bus.w_rd = 0; bus.m_rs2 = 0; #1;
    n_cmp++; if (bus.wm_fwd_sel !== 1'b0) begin n_bad++; $display("FAIL wm_fwd_x0 got %b want 0", bus.wm_fwd_sel); end
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.e_valid = 1; bus.e_memren = 1; bus.e_rd = 5;
    bus.d_valid = 1; bus.d_uses_rs1 = 1; bus.d_rs1 = 5;
    step(); bus.e_valid = 0;
    for (int i = 2; i < WLIM; i++) step();
    n_cmp++; if (bus.watchdog_err !== 1'b0) begin n_bad++; $display("FAIL wdog_early got %b want 0", bus.watchdog_err); end
    step();
    n_cmp++; if (bus.watchdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_set got %b want 1", bus.watchdog_err); end
    bus.d_valid = 0; step(); step();
    n_cmp++; if (bus.watchdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_sticky got %b want 1", bus.watchdog_err); end
    do_reset(); #1;
    n_cmp++; if ({bus.watchdog_err, bus.sb_busy} !== 2'b00) begin n_bad++; $display("FAIL wdog_reset got %b want 00", {bus.watchdog_err, bus.sb_busy}); end
  endtask

  task automatic test_random();
    bit pend_m[NREG];
    int outst_m, wdog_m, scnt_m, fcnt_m;
    bit err_m, eld, stl, rdr, any;
    logic [1:0] s1, s2;
    do_reset();
    foreach (pend_m[i]) pend_m[i] = 0;
    outst_m = 0; wdog_m = 0; err_m = 0; scnt_m = 0; fcnt_m = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      bus.d_valid = $urandom_range(0, 3) != 0;
      bus.d_uses_rs1 = $urandom_range(0, 1); bus.d_uses_rs2 = $urandom_range(0, 1);
      bus.d_memren = $urandom_range(0, 2) == 0;
      bus.d_rs1 = 5'($urandom_range(0, 7)); bus.d_rs2 = 5'($urandom_range(0, 7));
      bus.e_valid = $urandom_range(0, 1); bus.e_memren = $urandom_range(0, 2) == 0;
      bus.e_redirect = $urandom_range(0, 9) == 0;
      bus.e_rs1 = 5'($urandom_range(0, 7)); bus.e_rs2 = 5'($urandom_range(0, 7));
      bus.e_rd = 5'($urandom_range(0, 7));
      bus.m_rd = 5'($urandom_range(0, 7)); bus.m_rs2 = 5'($urandom_range(0, 7));
      bus.m_regwren = $urandom_range(0, 1); bus.m_memren = $urandom_range(0, 3) == 0;
      bus.m_memwren = $urandom_range(0, 1);
      bus.w_rd = 5'($urandom_range(0, 7)); bus.w_regwren = $urandom_range(0, 1);
      bus.ld_rsp_valid = $urandom_range(0, 2) == 0; bus.ld_rsp_rd = 5'($urandom_range(0, 7));
      #1;
      eld = bus.e_valid && bus.e_memren && bus.e_rd != 0;
      stl = bus.d_valid && (
              (bus.d_uses_rs1 && bus.d_rs1 != 0 && (pend_m[bus.d_rs1] || (eld && bus.e_rd == bus.d_rs1))) ||
              (bus.d_uses_rs2 && bus.d_rs2 != 0 && (pend_m[bus.d_rs2] || (eld && bus.e_rd == bus.d_rs2))) ||
              (bus.d_uses_rs1 && bus.w_regwren && bus.w_rd != 0 && bus.w_rd == bus.d_rs1) ||
              (bus.d_uses_rs2 && bus.w_regwren && bus.w_rd != 0 && bus.w_rd == bus.d_rs2) ||
              (bus.d_memren && (outst_m + int'(eld) >= MAXO)));
      rdr = bus.e_valid && bus.e_redirect;
      s1 = (bus.m_regwren && !bus.m_memren && bus.m_rd != 0 && bus.m_rd == bus.e_rs1) ? 2'b01 :
           (bus.w_regwren && bus.w_rd != 0 && bus.w_rd == bus.e_rs1) ? 2'b10 : 2'b00;
      s2 = (bus.m_regwren && !bus.m_memren && bus.m_rd != 0 && bus.m_rd == bus.e_rs2) ? 2'b01 :
           (bus.w_regwren && bus.w_rd != 0 && bus.w_rd == bus.e_rs2) ? 2'b10 : 2'b00;
      any = 0; foreach (pend_m[i]) any |= pend_m[i];
      n_cmp++; if ({bus.stall_if, bus.ifid_wren, bus.ifid_flush, bus.idex_flush} !== {stl && !rdr, !stl || rdr, rdr, stl || rdr}) begin
        n_bad++; $display("FAIL rnd_ctrl cyc %0d got %b want %b", cyc, {bus.stall_if, bus.ifid_wren, bus.ifid_flush, bus.idex_flush}, {stl && !rdr, !stl || rdr, rdr, stl || rdr}); end
      n_cmp++; if ({bus.rs1_sel, bus.rs2_sel} !== {s1, s2}) begin n_bad++; $display("FAIL rnd_fwd cyc %0d got %b want %b", cyc, {bus.rs1_sel, bus.rs2_sel}, {s1, s2}); end
      n_cmp++; if (bus.wm_fwd_sel !== (bus.m_memwren && bus.w_regwren && bus.w_rd != 0 && bus.w_rd == bus.m_rs2)) begin
        n_bad++; $display("FAIL rnd_wm cyc %0d got %b", cyc, bus.wm_fwd_sel); end
      n_cmp++; if ({bus.sb_busy, bus.watchdog_err} !== {any, err_m}) begin n_bad++; $display("FAIL rnd_state cyc %0d got %b want %b", cyc, {bus.sb_busy, bus.watchdog_err}, {any, err_m}); end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++; if ({bus.stall_cycles, bus.flush_events} !== {16'(scnt_m), 16'(fcnt_m)}) begin n_bad++; $display("FAIL rnd_cnt cyc %0d got %h want %h", cyc, {bus.stall_cycles, bus.flush_events}, {16'(scnt_m), 16'(fcnt_m)}); end
`else
      n_cmp++; if ({bus.stall_cycles, bus.flush_events} !== 32'd0) begin n_bad++; $display("FAIL rnd_cnt cyc %0d got %h want 0", cyc, {bus.stall_cycles, bus.flush_events}); end
`endif
      if (reset) begin
        foreach (pend_m[i]) pend_m[i] = 0;
        outst_m = 0; wdog_m = 0; err_m = 0; scnt_m = 0; fcnt_m = 0;
      end else begin
        if (bus.ld_rsp_valid && bus.ld_rsp_rd != 0) pend_m[bus.ld_rsp_rd] = 0;
        if (eld) pend_m[bus.e_rd] = 1;
        outst_m = outst_m + int'(eld) - int'(bus.ld_rsp_valid && outst_m > 0);
        if (outst_m > 15) outst_m = 15;
        wdog_m = (stl && !rdr) ? ((wdog_m < WLIM) ? wdog_m + 1 : WLIM) : 0;
        if (wdog_m == WLIM) err_m = 1;
        if (stl && !rdr && scnt_m < 65535) scnt_m++;
        if (rdr && fcnt_m < 65535) fcnt_m++;
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_outst_limit();
    test_redirect();
    test_forwarding();
    test_store_fwd();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
